// File: rtl/video_pkg.sv
// Shared video constants: pattern mode encodings, colour palette and default resolution.
package video_pkg;

  localparam int H_DISP_DEF = 3840;
  localparam int V_DISP_DEF = 2160;

  typedef enum logic [1:0] {
    MODE_BARS = 2'd0,
    MODE_GRID = 2'd1,
    MODE_GRAD = 2'd2,
    MODE_BOX  = 2'd3
  } mode_t;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_BOX_BG  = 24'h000040;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_box_mover.sv
// Bouncing-box position: steps once per frame and reflects off the active-area edges.
module pattern_box_mover #(
  parameter int H_DISP   = 3840,
  parameter int V_DISP   = 2160,
  parameter int BOX_SIZE = 128,
  parameter int BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [12:0] box_x,
  output logic [11:0] box_y
);

  // Turning thresholds: one more step forward would push the box past the edge.
  localparam logic [12:0] X_TURN = 13'(H_DISP - BOX_SIZE - BOX_STEP);
  localparam logic [12:0] X_MAX  = 13'(H_DISP - BOX_SIZE);
  localparam logic [12:0] X_STEP = 13'(BOX_STEP);
  localparam logic [11:0] Y_TURN = 12'(V_DISP - BOX_SIZE - BOX_STEP);
  localparam logic [11:0] Y_MAX  = 12'(V_DISP - BOX_SIZE);
  localparam logic [11:0] Y_STEP = 12'(BOX_STEP);

  logic dir_x, dir_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_start) begin
      if (dir_x) begin
        if (box_x >= X_TURN) begin
          box_x <= X_MAX;
          dir_x <= 1'b0;
        end else begin
          box_x <= box_x + X_STEP;
        end
      end else if (box_x <= X_STEP) begin
        box_x <= '0;
        dir_x <= 1'b1;
      end else begin
        box_x <= box_x - X_STEP;
      end

      if (dir_y) begin
        if (box_y >= Y_TURN) begin
          box_y <= Y_MAX;
          dir_y <= 1'b0;
        end else begin
          box_y <= box_y + Y_STEP;
        end
      end else if (box_y <= Y_STEP) begin
        box_y <= '0;
        dir_y <= 1'b1;
      end else begin
        box_y <= box_y - Y_STEP;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: own x/y counters, four patterns, pixel returned one clock
// after data_req so it lines up with the timing driver's registered data-enable.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_DISP     = H_DISP_DEF,
  parameter int V_DISP     = V_DISP_DEF,
  parameter int BAR_W      = 480,
  parameter int GRID_SHIFT = 7,
  parameter int BOX_SIZE   = 128,
  parameter int BOX_STEP   = 4
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        data_req,
  input  logic        video_vs,
  input  logic [1:0]  mode,
  output logic [23:0] pixel_data,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [12:0] BAR_LAST = 13'(BAR_W - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_DISP - 1);
  localparam logic [13:0] BOX_W14  = 14'(BOX_SIZE);

  logic [12:0] x_cnt;
  logic [11:0] y_cnt;
  logic [12:0] bar_pos;
  logic [2:0]  bar_idx;
  mode_t       mode_q;
  logic        vs_d, req_d;
  logic [12:0] box_x;
  logic [11:0] box_y;
  logic        line_end, in_box;
  logic [23:0] pix_nxt;

  assign line_end = req_d & ~data_req;

  pattern_box_mover #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_box (
    .clk        (pixel_clk),
    .rst        (sys_rst),
    .frame_start(frame_start),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  // 14-bit sums so box edge + size cannot wrap at the right/bottom border.
  always_comb begin
    in_box = ({1'b0, x_cnt} >= {1'b0, box_x}) &&
             ({1'b0, x_cnt} <  ({1'b0, box_x} + BOX_W14)) &&
             ({2'b0, y_cnt} >= {2'b0, box_y}) &&
             ({2'b0, y_cnt} <  ({2'b0, box_y} + BOX_W14));
    pix_nxt = C_BLACK;
    case (mode_q)
      MODE_BARS: pix_nxt = bar_colour(bar_idx);
      MODE_GRID: pix_nxt = (x_cnt[GRID_SHIFT-1:0] == '0 || y_cnt[GRID_SHIFT-1:0] == '0)
                           ? C_WHITE : C_BLACK;
      MODE_GRAD: pix_nxt = {x_cnt[11:4], y_cnt[11:4], frame_cnt};
      default:   pix_nxt = in_box ? C_WHITE : C_BOX_BG;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pixel_data  <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      mode_q      <= MODE_BARS;
      vs_d        <= 1'b1;
      req_d       <= 1'b0;
    end else begin
      vs_d        <= video_vs;
      req_d       <= data_req;
      frame_start <= vs_d & ~video_vs;

      // Bar index tracked with a wrapping sub-counter instead of x_cnt / BAR_W.
      if (data_req) begin
        x_cnt <= x_cnt + 13'd1;
        if (bar_pos == BAR_LAST) begin
          bar_pos <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + 13'd1;
        end
      end else begin
        x_cnt   <= '0;
        bar_pos <= '0;
        bar_idx <= '0;
      end

      if (frame_start)
        y_cnt <= '0;
      else if (line_end && y_cnt < Y_LAST)
        y_cnt <= y_cnt + 12'd1;

      if (frame_start) begin
        mode_q    <= mode_t'(mode);
        frame_cnt <= frame_cnt + 8'd1;
      end

      pixel_data <= data_req ? pix_nxt : '0;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench: per-cycle scoreboard against a behavioural model plus a table of
// hand-derived pixel spot checks keyed by frame sequence number and x/y position.
module tb_video_pattern_gen;

  localparam int H  = 64;
  localparam int V  = 20;
  localparam int BW = 8;
  localparam int GS = 3;
  localparam int BS = 16;
  localparam int ST = 4;
  localparam int HB = 4;

  logic        pixel_clk = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        data_req  = 1'b0;
  logic        video_vs  = 1'b1;
  logic [1:0]  mode      = 2'd0;
  logic [23:0] pixel_data;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  video_pattern_gen #(
    .H_DISP(H), .V_DISP(V), .BAR_W(BW), .GRID_SHIFT(GS), .BOX_SIZE(BS), .BOX_STEP(ST)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .data_req   (data_req),
    .video_vs   (video_vs),
    .mode       (mode),
    .pixel_data (pixel_data),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int          seq;
    int          x;
    int          y;
    logic [23:0] px;
  } spot_t;

  spot_t       spots[$];
  logic [23:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  int          mx, my, mbx, mby, seq;
  logic        mdx, mdy, mprev;
  logic [1:0]  mmode;
  logic [7:0]  mfc;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_spot(input int s, input int x, input int y, input logic [23:0] p);
    spot_t e;
    e.seq = s; e.x = x; e.y = y; e.px = p;
    spots.push_back(e);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mbx = 0; mby = 0;
    mdx = 1'b1; mdy = 1'b1; mprev = 1'b0;
    mmode = 2'd0; mfc = 8'd0;
  endtask

  function automatic logic [23:0] model_px(input int x, input int y);
    logic [23:0] r;
    r = 24'h0;
    case (mmode)
      2'd0: case (x / BW)
        0: r = 24'hFFFFFF;  1: r = 24'hFFFF00;  2: r = 24'h00FFFF;  3: r = 24'h00FF00;
        4: r = 24'hFF00FF;  5: r = 24'hFF0000;  6: r = 24'h0000FF;  default: r = 24'h000000;
      endcase
      2'd1: r = ((x % (1 << GS)) == 0 || (y % (1 << GS)) == 0) ? 24'hFFFFFF : 24'h000000;
      2'd2: r = {8'(x >> 4), 8'(y >> 4), mfc};
      default: r = (x >= mbx && x < mbx + BS && y >= mby && y < mby + BS) ? 24'hFFFFFF : 24'h000040;
    endcase
    return r;
  endfunction

  task automatic tick(input logic req);
    logic        sp;
    logic [23:0] spx;
    string       sname;
    data_req = req;
    sp = 1'b0; spx = 24'h0; sname = "";
    sb.push_back(req ? model_px(mx, my) : 24'h0);
    if (req)
      foreach (spots[i])
        if (spots[i].seq == seq && spots[i].x == mx && spots[i].y == my) begin
          sp = 1'b1; spx = spots[i].px;
          sname = $sformatf("spot s%0d x%0d y%0d", seq, mx, my);
        end
    @(posedge pixel_clk); #1;
    if (sb.size() == 0) check("sb_underflow", 24'd1, 24'd0);
    else check("pixel", pixel_data, sb.pop_front());
    if (sp) check(sname, pixel_data, spx);
    if (req) mx++; else mx = 0;
    if (mprev && !req && my < V - 1) my++;
    mprev = req;
  endtask

  task automatic vsync();
    video_vs = 1'b0;
    tick(1'b0);
    check("fs_pulse", 24'(frame_start), 24'd1);
    tick(1'b0);
    mfc++;
    mmode = mode;
    my = 0;
    seq++;
    if (mdx) begin
      if (mbx >= H - BS - ST) begin mbx = H - BS; mdx = 1'b0; end else mbx += ST;
    end else begin
      if (mbx <= ST) begin mbx = 0; mdx = 1'b1; end else mbx -= ST;
    end
    if (mdy) begin
      if (mby >= V - BS - ST) begin mby = V - BS; mdy = 1'b0; end else mby += ST;
    end else begin
      if (mby <= ST) begin mby = 0; mdy = 1'b1; end else mby -= ST;
    end
    check("fs_width", 24'(frame_start), 24'd0);
    check("frame_cnt", 24'(frame_cnt), 24'(mfc));
    video_vs = 1'b1;
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic line();
    for (int i = 0; i < H; i++) tick(1'b1);
    for (int i = 0; i < HB; i++) tick(1'b0);
  endtask

  task automatic frame(input logic [1:0] m, input int nl);
    mode = m;
    vsync();
    for (int l = 0; l < nl; l++) line();
  endtask

  initial begin
    // bars
    add_spot(1, 0, 0, 24'hFFFFFF);  add_spot(1, 7, 0, 24'hFFFFFF);
    add_spot(1, 8, 0, 24'hFFFF00);  add_spot(1, 16, 1, 24'h00FFFF);
    add_spot(2, 24, 2, 24'h00FF00); add_spot(2, 32, 0, 24'hFF00FF);
    add_spot(3, 40, 3, 24'hFF0000); add_spot(3, 48, 0, 24'h0000FF);
    add_spot(3, 63, 0, 24'h000000);
    // grid
    add_spot(4, 0, 0, 24'hFFFFFF);  add_spot(4, 5, 0, 24'hFFFFFF);
    add_spot(4, 0, 1, 24'hFFFFFF);  add_spot(4, 8, 1, 24'hFFFFFF);
    add_spot(4, 16, 1, 24'hFFFFFF); add_spot(4, 1, 1, 24'h000000);
    add_spot(4, 9, 3, 24'h000000);
    // gradient
    add_spot(5, 32, 16, 24'h020105); add_spot(5, 63, 19, 24'h030105);
    add_spot(5, 0, 0, 24'h000005);
    // mid-frame mode change, then gradient next frame
    add_spot(6, 8, 2, 24'hFFFF00);  add_spot(7, 16, 0, 24'h010007);
    add_spot(7, 8, 0, 24'h000007);
    // box bounce
    add_spot(8, 32, 0, 24'hFFFFFF);  add_spot(8, 31, 0, 24'h000040);
    add_spot(8, 47, 15, 24'hFFFFFF); add_spot(8, 48, 0, 24'h000040);
    add_spot(8, 32, 16, 24'h000040);
    add_spot(12, 48, 0, 24'hFFFFFF); add_spot(12, 47, 0, 24'h000040);
    add_spot(12, 63, 0, 24'hFFFFFF);
    add_spot(13, 44, 4, 24'hFFFFFF); add_spot(13, 43, 4, 24'h000040);
    add_spot(13, 44, 0, 24'h000040);
    add_spot(24, 0, 0, 24'hFFFFFF);  add_spot(24, 15, 0, 24'hFFFFFF);
    add_spot(24, 16, 0, 24'h000040);
    add_spot(25, 4, 4, 24'hFFFFFF);  add_spot(25, 3, 4, 24'h000040);
    // after mid-line reset
    add_spot(283, 4, 4, 24'hFFFFFF); add_spot(283, 3, 4, 24'h000040);
    add_spot(284, 32, 0, 24'h020002);

    model_reset();
    seq = 0;
    #1;
    check("rst_pixel", pixel_data, 24'h0);
    check("rst_fs", 24'(frame_start), 24'd0);
    check("rst_fcnt", 24'(frame_cnt), 24'd0);
    tick(1'b0); tick(1'b0);
    sys_rst = 1'b0;
    tick(1'b0);

    for (int f = 0; f < 3; f++) frame(2'd0, 4);
    frame(2'd1, 4);
    frame(2'd2, V);
    frame(2'd0, 2);
    mode = 2'd2;
    line(); line();
    frame(2'd2, 2);
    frame(2'd3, V);
    for (int f = 9; f <= 25; f++) frame(2'd3, 6);
    for (int f = 26; f <= 281; f++) frame(2'd1, 0);

    // reset asserted part-way through a line
    frame(2'd2, 1);
    for (int i = 0; i < 20; i++) tick(1'b1);
    sys_rst = 1'b1;
    #2;
    check("midrst_pixel", pixel_data, 24'h0);
    check("midrst_fcnt", 24'(frame_cnt), 24'd0);
    model_reset();
    tick(1'b0); tick(1'b0);
    sys_rst = 1'b0;
    tick(1'b0); tick(1'b0);
    frame(2'd3, 6);
    frame(2'd2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
